usb_uart_in_buffer: RTL and testbench
=====================================

// Module: usb_uart_in_buffer
// PURPOSE
//  Byte FIFO that sits directly upstream of usb_uart's uart_in_* pipeline (device -> host).
//  Holds user bytes and releases them in bursts, so the bulk IN endpoint sends fuller packets.
//  A burst is released at a fill threshold, after an idle timeout, or on an explicit flush.
//  Also has a discard mode that drops all traffic, for use when no host is present.
// PARAMETERS
//  DEPTH    64     FIFO entries; power of 2, >= 4
//  BURST    32     level that triggers a drain; 1..DEPTH
//  TIMEOUT  48000  idle cycles before a partial buffer drains (1 ms at 48 MHz); >= 1
// PORTS
//  clk_48mhz      in   1         sole clock, rising edge
//  reset_n        in   1         synchronous reset, active-low
//  in_data        in   8         byte from user logic
//  in_valid       in   1         in_data valid
//  in_ready       out  1         buffer accepts in_data this cycle
//  flush          in   1         drain now if level > 0 (sampled each cycle, not latched)
//  discard        in   1         drop buffered and incoming bytes while high
//  uart_in_data   out  8         to usb_uart uart_in_data
//  uart_in_valid  out  1         to usb_uart uart_in_valid
//  uart_in_ready  in   1         from usb_uart uart_in_ready
//  level          out  LW        entries held; LW = $clog2(DEPTH)+1
// BEHAVIOUR
//  Transfers: push = in_valid & in_ready; pop = uart_in_valid & uart_in_ready.
//  Reset (reset_n=0 at an edge): rd/wr pointers=0; level=0; timer=0; state=FILL.
//  Reset output values: uart_in_valid=0; in_ready=1; level=0; uart_in_data undefined.
//  A reset mid-drain abandons all stored bytes.
//  in_ready = (level != DEPTH) | discard. When full, no push even if a pop occurs that cycle.
//  level: +1 on push only, -1 on pop only, unchanged on push+pop. Never wraps.
//  Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
//  uart_in_data = mem[rd_ptr] (first-word fall-through).
//  uart_in_data and uart_in_valid hold stable while uart_in_valid=1 and uart_in_ready=0 (except discard).
//  uart_in_valid = (state==DRAIN) & (level!=0) & ~discard.
//  Timer:
//   - Cleared on push, or when state==DRAIN, or when level==0.
//   - Otherwise increments each cycle and saturates at TIMEOUT.
//  State FILL: uart_in_valid=0. Move to DRAIN at the next edge if level>0 and any of:
//   - level >= BURST
//   - timer == TIMEOUT
//   - flush == 1
//   flush while level==0 is ignored.
//  State DRAIN: pop on every ready cycle. Pushes are still accepted while draining.
//   Move to FILL when the next level is 0 (pop with level==1 and no push).
//  Latency (FIFO empty, in FILL):
//   - BURST=1: byte accepted at edge t -> uart_in_valid=1 in the cycle after edge t+1.
//   - Timeout: last push at edge t -> timer==TIMEOUT after edge t+TIMEOUT -> DRAIN after edge t+TIMEOUT+1.
//   - flush high in cycle c with level>0 -> uart_in_valid=1 in cycle c+1.
//  Discard (discard=1), applied at each edge:
//   - Pointers reset, level=0, timer=0, state=FILL.
//   - Pushes are acknowledged (in_ready=1) and dropped.
//   - uart_in_valid drops to 0 immediately, even mid-handshake. This is the one allowed
//     exception to the valid-stability rule.
//  discard has priority over flush, push and pop.
// TESTING (DEPTH=64, BURST=4, TIMEOUT=16 unless stated; uart_in_ready=1 unless stated)
//  1 Push 0x41,0x42,0x43 on consecutive edges.
//    -> uart_in_valid stays 0 for 16 cycles after the last push.
//    -> then 0x41,0x42,0x43 on 3 consecutive cycles; level returns to 0; state FILL.
//  2 Push 0x10..0x13.
//    -> uart_in_valid rises 2 cycles after the 4th push; 0x10..0x13 in order; no timeout wait.
//  3 uart_in_ready=0, push 0x00..0x3F.
//    -> level=64, in_ready=0, uart_in_data holds 0x00.
//    Raise ready.
//    -> 0x00..0x3F in order; in_ready=1 after the first pop.
//  4 In DRAIN at level=5, push and pop in the same cycle.
//    -> level stays 5; byte order is preserved across the wrap at rd_ptr 63 -> 0.
//  5 Push 2 bytes, then pulse flush one cycle.
//    -> uart_in_valid in the next cycle.
//    flush with level=0 -> no state change.
//  6 discard=1 at level=10 mid-drain.
//    -> after the edge: level=0, uart_in_valid=0, in_ready=1; pushes during discard dropped.
//    Also: reset_n=0 mid-drain -> level=0, uart_in_valid=0, in_ready=1.

Source files
------------

// File: rtl/usb_uart_in_buffer.sv
// usb_uart_in_buffer: byte FIFO ahead of the usb_uart IN pipeline.
// Bytes collect in FILL and are released in DRAIN once the buffer reaches
// the burst level, has sat idle for TIMEOUT cycles, or a flush arrives.
// discard empties the buffer and swallows incoming bytes while high.
module usb_uart_in_buffer #(
   parameter  int DEPTH   = 64,
   parameter  int BURST   = 32,
   parameter  int TIMEOUT = 48000,
   localparam int AW      = $clog2(DEPTH),
   localparam int LW      = AW + 1,
   localparam int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic          clk_48mhz,
   input  logic          reset_n,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          flush,
   input  logic          discard,
   output logic [7:0]    uart_in_data,
   output logic          uart_in_valid,
   input  logic          uart_in_ready,
   output logic [LW-1:0] level
);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    mem [DEPTH];

   logic push, pop;

   // Handshakes; discard keeps the input side open so upstream never stalls
   always_comb begin
      in_ready      = (level_q != LW'(DEPTH)) | discard;
      uart_in_valid = (state_q == DRAIN) & (level_q != '0) & ~discard;
      uart_in_data  = mem[rd_ptr_q];
      level         = level_q;
      push          = in_valid & in_ready;
      pop           = uart_in_valid & uart_in_ready;
   end

   // Next-state: pointers, level, idle timer and FILL/DRAIN decision
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      timer_d  = timer_q;
      if (discard) begin
         state_d  = FILL;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
         timer_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
         // Timer only runs while a partial buffer sits idle in FILL
         if (push || state_q == DRAIN || level_q == '0)
            timer_d = '0;
         else if (timer_q != TW'(TIMEOUT))
            timer_d = timer_q + 1'b1;
         case (state_q)
            FILL: begin
               if (level_q != '0 && (level_q >= LW'(BURST) ||
                                     timer_q == TW'(TIMEOUT) || flush))
                  state_d = DRAIN;
            end
            DRAIN: begin
               if (level_d == '0) state_d = FILL;
            end
            default: state_d = FILL;
         endcase
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) begin
         state_q  <= FILL;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         timer_q  <= timer_d;
      end
   end

   // Byte storage; no reset needed since level gates what is visible
   always_ff @(posedge clk_48mhz) begin
      if (push && !discard) mem[wr_ptr_q] <= in_data;
   end

endmodule

// File: tb/tb_usb_uart_in_buffer.sv
// Directed bench for usb_uart_in_buffer (DEPTH=64, BURST=4, TIMEOUT=16).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
module tb_usb_uart_in_buffer;

   localparam int LW = 7;

   logic          clk_48mhz = 1'b0;
   logic          reset_n   = 1'b0;
   logic [7:0]    in_data   = '0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic          flush     = 1'b0;
   logic          discard   = 1'b0;
   logic [7:0]    uart_in_data;
   logic          uart_in_valid;
   logic          uart_in_ready = 1'b1;
   logic [LW-1:0] level;

   int total = 0;
   int bad   = 0;

   usb_uart_in_buffer #(.DEPTH(64), .BURST(4), .TIMEOUT(16)) dut (
      .clk_48mhz    (clk_48mhz),
      .reset_n      (reset_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .flush        (flush),
      .discard      (discard),
      .uart_in_data (uart_in_data),
      .uart_in_valid(uart_in_valid),
      .uart_in_ready(uart_in_ready),
      .level        (level)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   // advance past the next rising edge, then let outputs settle
   task automatic cyc();
      @(posedge clk_48mhz);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      cyc();
      in_valid = 1'b0;
      #1;
   endtask

   initial begin
      // reset
      reset_n = 1'b0;
      cyc(); cyc();
      reset_n = 1'b1;
      #1;
      chk("rst_valid", uart_in_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_level", level, 0);

      // 1: three bytes drain only after the idle timeout
      push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
      chk("t1_level", level, 3);
      chk("t1_idle0", uart_in_valid, 0);
      for (int k = 1; k <= 16; k++) begin
         cyc();
         chk($sformatf("t1_idle%0d", k), uart_in_valid, 0);
      end
      cyc();
      for (int k = 0; k < 3; k++) begin
         chk("t1_valid", uart_in_valid, 1);
         chk("t1_data", uart_in_data, 8'h41 + k);
         cyc();
      end
      chk("t1_done_valid", uart_in_valid, 0);
      chk("t1_done_level", level, 0);

      // 2: burst level triggers drain without waiting
      for (int k = 0; k < 4; k++) push_byte(8'h10 + k[7:0]);
      chk("t2_fill", uart_in_valid, 0);
      cyc();
      for (int k = 0; k < 4; k++) begin
         chk("t2_valid", uart_in_valid, 1);
         chk("t2_data", uart_in_data, 8'h10 + k);
         cyc();
      end
      chk("t2_done_valid", uart_in_valid, 0);
      chk("t2_done_level", level, 0);

      // 3: fill to full under backpressure
      uart_in_ready = 1'b0;
      for (int k = 0; k < 64; k++) push_byte(k[7:0]);
      chk("t3_level", level, 64);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_hold_valid", uart_in_valid, 1);
      chk("t3_hold_data", uart_in_data, 8'h00);
      // full + pop in the same cycle: the offered byte must not be taken
      in_valid = 1'b1; in_data = 8'hEE; uart_in_ready = 1'b1;
      #1;
      chk("t3_full_ready", in_ready, 0);
      cyc();
      in_valid = 1'b0;
      #1;
      chk("t3_after_pop_level", level, 63);
      chk("t3_after_pop_ready", in_ready, 1);
      for (int k = 1; k < 64; k++) begin
         chk("t3_valid", uart_in_valid, 1);
         chk("t3_data", uart_in_data, k);
         cyc();
      end
      chk("t3_done_valid", uart_in_valid, 0);
      chk("t3_done_level", level, 0);

      // 4: steady push+pop at level 5 across the pointer wrap
      uart_in_ready = 1'b0;
      for (int k = 0; k < 5; k++) push_byte(8'h80 + k[7:0]);
      chk("t4_level", level, 5);
      uart_in_ready = 1'b1;
      for (int k = 0; k < 70; k++) begin
         in_valid = 1'b1;
         in_data  = 8'h85 + k[7:0];
         #1;
         chk("t4_valid", uart_in_valid, 1);
         chk("t4_data", uart_in_data, (8'h80 + k) & 8'hFF);
         chk("t4_level", level, 5);
         cyc();
      end
      in_valid = 1'b0;
      #1;
      for (int k = 70; k < 75; k++) begin
         chk("t4_tail", uart_in_data, (8'h80 + k) & 8'hFF);
         cyc();
      end
      chk("t4_done_level", level, 0);
      chk("t4_done_valid", uart_in_valid, 0);

      // 5: flush releases a partial buffer next cycle
      push_byte(8'h21); push_byte(8'h22);
      chk("t5_fill", uart_in_valid, 0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      #1;
      chk("t5_valid", uart_in_valid, 1);
      chk("t5_data0", uart_in_data, 8'h21);
      cyc();
      chk("t5_data1", uart_in_data, 8'h22);
      cyc();
      chk("t5_done_valid", uart_in_valid, 0);
      // flush on an empty buffer must leave us in FILL
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      #1;
      chk("t5_empty_level", level, 0);
      push_byte(8'h30);
      chk("t5_still_fill", uart_in_valid, 0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      #1;
      chk("t5_flush2_data", uart_in_data, 8'h30);
      cyc();
      chk("t5_flush2_level", level, 0);

      // 6: discard mid-drain
      uart_in_ready = 1'b0;
      for (int k = 0; k < 10; k++) push_byte(8'h60 + k[7:0]);
      chk("t6_level", level, 10);
      chk("t6_valid", uart_in_valid, 1);
      discard = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      #1;
      chk("t6_disc_valid_now", uart_in_valid, 0);
      chk("t6_disc_ready", in_ready, 1);
      cyc();
      chk("t6_disc_level", level, 0);
      cyc();
      chk("t6_disc_level2", level, 0);
      discard = 1'b0; in_valid = 1'b0;
      #1;
      chk("t6_after_level", level, 0);
      chk("t6_after_valid", uart_in_valid, 0);
      chk("t6_after_ready", in_ready, 1);

      // reset mid-drain abandons stored bytes
      for (int k = 0; k < 5; k++) push_byte(8'h70 + k[7:0]);
      chk("t6_pre_rst_valid", uart_in_valid, 1);
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      #1;
      chk("t6_rst_level", level, 0);
      chk("t6_rst_valid", uart_in_valid, 0);
      chk("t6_rst_ready", in_ready, 1);
      uart_in_ready = 1'b1;
      push_byte(8'h77);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      #1;
      chk("t6_new_data", uart_in_data, 8'h77);
      cyc();
      chk("t6_new_level", level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
